// File: rtl/bit_serializer_pkg.sv
// -----------------------------------------------------------------------------
// serial_pkg
//   Shared definitions for the bit_serializer front end and the downstream
//   00110 sequence detector bench.
//   Contents:
//     ser_state_t        - serializer FSM states {IDLE, SHIFT}
//     SER_DEFAULT_WIDTH  - default word width (5, matches detector pattern length)
//     SER_DEFAULT_DEPTH  - default input FIFO depth (2)
// -----------------------------------------------------------------------------
package serial_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_t;

  localparam int unsigned SER_DEFAULT_WIDTH = 5;
  localparam int unsigned SER_DEFAULT_DEPTH = 2;

endpackage : serial_pkg

// File: rtl/bit_serializer_fifo.sv
// -----------------------------------------------------------------------------
// ser_fifo
//   Synchronous single-clock FIFO used as the input word buffer of
//   bit_serializer. Read data is presented combinationally from the head entry;
//   a pop consumes it at the rising edge.
//   Parameters:
//     WIDTH  - bits per entry
//     DEPTH  - number of entries (power of two, >= 2)
//   Ports:
//     clk    in   clock, rising edge
//     rst    in   asynchronous active-high reset (empties the FIFO)
//     push   in   write wdata this cycle (ignored when full)
//     wdata  in   entry to write
//     pop    in   consume head entry this cycle (ignored when empty)
//     rdata  out  head entry
//     full   out  count == DEPTH
//     empty  out  count == 0
//     count  out  number of stored entries
// -----------------------------------------------------------------------------
module ser_fifo
  import serial_pkg::*;
#(
  parameter int WIDTH = SER_DEFAULT_WIDTH,
  parameter int DEPTH = SER_DEFAULT_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;

  logic w_push;
  logic w_pop;

  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  assign full  = (r_count == FULL_CNT);
  assign empty = (r_count == '0);
  assign count = r_count;
  assign rdata = r_mem[r_rptr];

  // Storage carries no reset: contents are only observable through rdata
  // when count is non-zero, and count is reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= wdata;
    end
  end

  // Pointers are exactly log2(DEPTH) bits, so increments wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule : ser_fifo

// File: rtl/bit_serializer.sv
// -----------------------------------------------------------------------------
// bit_serializer
//   Parallel-to-serial front end for the 00110 Mealy sequence detector.
//   Words arrive over a valid/ready handshake into a small FIFO and are shifted
//   out one bit per clock on ser_bit. Consecutive words stream with no idle bit
//   between them so patterns straddling a word boundary remain detectable.
//   Build option:
//     BIT_SERIALIZER_MSB_FIRST_EN  defined   -> in_data[WIDTH-1] first, shift left
//                                  undefined -> in_data[0] first, shift right
//   Parameters:
//     WIDTH  - bits per word, 2..32
//     DEPTH  - FIFO entries, power of two, >= 2
//   Ports:
//     clk        in   clock, rising edge
//     rst        in   asynchronous active-high reset
//     in_valid   in   in_data holds a word
//     in_data    in   word to serialize (held by the source until accepted)
//     in_ready   out  FIFO can accept a word this cycle (not full, no bypass)
//     ser_bit    out  serial data bit (detector ip)
//     ser_valid  out  ser_bit carries a payload bit
//     word_done  out  high while the last bit of a word is presented
//     busy       out  FSM in SHIFT or FIFO non-empty
// -----------------------------------------------------------------------------
module bit_serializer
  import serial_pkg::*;
#(
  parameter int WIDTH = SER_DEFAULT_WIDTH,
  parameter int DEPTH = SER_DEFAULT_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             ser_bit,
  output logic             ser_valid,
  output logic             word_done,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  ser_state_t       r_state;
  logic [WIDTH-1:0] r_shift;     // bits still to be sent after the one on ser_bit
  logic [CW-1:0]    r_bitcnt;    // index of the bit currently on ser_bit
  logic             r_ser_bit;
  logic             r_ser_valid;
  logic             r_word_done;

  logic             w_push;
  logic             w_pop;
  logic             w_fifo_full;
  logic             w_fifo_empty;
  logic [WIDTH-1:0] w_fifo_rdata;
  logic [AW:0]      w_fifo_count;
  logic             w_at_last;
  logic             w_first_bit;
  logic [WIDTH-1:0] w_load_shift;
  logic             w_next_bit;
  logic [WIDTH-1:0] w_next_shift;

  ser_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .wdata (in_data),
    .pop   (w_pop),
    .rdata (w_fifo_rdata),
    .full  (w_fifo_full),
    .empty (w_fifo_empty),
    .count (w_fifo_count)
  );

  assign in_ready  = !w_fifo_full;
  assign w_push    = in_valid && in_ready;
  assign w_at_last = (r_bitcnt == LAST_BIT);

  // A pop loads the next word and puts its first bit on ser_bit at the same
  // edge; this happens from IDLE or on the last bit of a word (zero gap).
  assign w_pop = !w_fifo_empty && ((r_state == IDLE) || w_at_last);

`ifdef BIT_SERIALIZER_MSB_FIRST_EN
  assign w_first_bit  = w_fifo_rdata[WIDTH-1];
  assign w_load_shift = w_fifo_rdata << 1;
  assign w_next_bit   = r_shift[WIDTH-1];
  assign w_next_shift = r_shift << 1;
`else
  assign w_first_bit  = w_fifo_rdata[0];
  assign w_load_shift = w_fifo_rdata >> 1;
  assign w_next_bit   = r_shift[0];
  assign w_next_shift = r_shift >> 1;
`endif

  // IDLE-with-data and SHIFT-at-last-bit-with-data share the load path, so the
  // pop decision is tested first and the state case only handles the rest.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_shift     <= '0;
      r_bitcnt    <= '0;
      r_ser_bit   <= 1'b0;
      r_ser_valid <= 1'b0;
      r_word_done <= 1'b0;
    end else if (w_pop) begin
      r_state     <= SHIFT;
      r_shift     <= w_load_shift;
      r_bitcnt    <= '0;
      r_ser_bit   <= w_first_bit;
      r_ser_valid <= 1'b1;
      r_word_done <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_ser_bit   <= 1'b0;
          r_ser_valid <= 1'b0;
          r_word_done <= 1'b0;
        end
        SHIFT: begin
          if (w_at_last) begin
            r_state     <= IDLE;
            r_ser_bit   <= 1'b0;
            r_ser_valid <= 1'b0;
            r_word_done <= 1'b0;
          end else begin
            r_shift     <= w_next_shift;
            r_bitcnt    <= r_bitcnt + CW'(1);
            r_ser_bit   <= w_next_bit;
            r_ser_valid <= 1'b1;
            // Registered one cycle early so it lines up with the last bit.
            r_word_done <= (r_bitcnt == (LAST_BIT - CW'(1)));
          end
        end
        default: begin
          r_state     <= IDLE;
          r_ser_bit   <= 1'b0;
          r_ser_valid <= 1'b0;
          r_word_done <= 1'b0;
        end
      endcase
    end
  end

  assign ser_bit   = r_ser_bit;
  assign ser_valid = r_ser_valid;
  assign word_done = r_word_done;
  assign busy      = (r_state == SHIFT) || (w_fifo_count != '0);

endmodule : bit_serializer

// File: tb/tb_bit_serializer.sv
// -----------------------------------------------------------------------------
// tb_bit_serializer
//   Self-checking bench for bit_serializer (WIDTH=5, DEPTH=2): table of single
//   words, multi-word streaming/full-FIFO sequences, mid-word reset, and a
//   randomized run checked against a bit-queue reference model.
// -----------------------------------------------------------------------------
module tb_bit_serializer;
  import serial_pkg::*;

  localparam int W = SER_DEFAULT_WIDTH;
  localparam int D = SER_DEFAULT_DEPTH;
  localparam logic [W-1:0] DET_PAT = 5'b00110;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic         ser_bit;
  logic         ser_valid;
  logic         word_done;
  logic         busy;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [W-1:0] word;
    logic [0:W-1] seq_lsb;   // transmitted order, leftmost first
    logic [0:W-1] seq_msb;
  } vec_t;

  vec_t tbl [6];

  bit_serializer #(
    .WIDTH (W),
    .DEPTH (D)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .ser_bit   (ser_bit),
    .ser_valid (ser_valid),
    .word_done (word_done),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // i-th transmitted bit of a word.
  function automatic logic tx_bit(input logic [W-1:0] w, input int i);
`ifdef BIT_SERIALIZER_MSB_FIRST_EN
    return w[W-1-i];
`else
    return w[i];
`endif
  endfunction

  task automatic push_word(input logic [W-1:0] d);
    int waited;
    waited   = 0;
    in_data  = d;
    in_valid = 1'b1;
    while (!in_ready && waited < 40) begin
      @(posedge clk);
      #1;
      waited++;
    end
    check("push_accept", in_ready, 1);
    if (in_ready) begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic run_single(input logic [W-1:0] word, input logic [0:W-1] seq, input string tag);
    logic [W-1:0] hist;
    hist = '1;
    @(negedge clk);
    in_data  = word;
    in_valid = 1'b1;
    check($sformatf("%s_ready", tag), in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check($sformatf("%s_lat_valid", tag), ser_valid, 0);
    check($sformatf("%s_lat_busy", tag), busy, 1);
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      check($sformatf("%s_valid%0d", tag, i), ser_valid, 1);
      check($sformatf("%s_bit%0d", tag, i), ser_bit, seq[i]);
      check($sformatf("%s_done%0d", tag, i), word_done, (i == W-1));
      hist = {hist[W-2:0], ser_bit};
    end
    check($sformatf("%s_detect", tag), (hist == DET_PAT), (seq == DET_PAT));
    @(negedge clk);
    check($sformatf("%s_end_valid", tag), ser_valid, 0);
    check($sformatf("%s_end_bit", tag), ser_bit, 0);
    check($sformatf("%s_end_done", tag), word_done, 0);
    check($sformatf("%s_end_busy", tag), busy, 0);
  endtask

  task automatic run_stream(input logic [W-1:0] words [4], input int n, input int exp_low,
                            input string tag);
    logic v_q[$];
    logic b_q[$];
    logic d_q[$];
    logic r_q[$];
    int   first;
    int   run;
    int   total;
    int   j;
    int   low;
    @(negedge clk);
    fork
      begin
        for (int k = 0; k < n; k++) push_word(words[k]);
      end
      begin
        for (int c = 0; c < 50; c++) begin
          @(negedge clk);
          v_q.push_back(ser_valid);
          b_q.push_back(ser_bit);
          d_q.push_back(word_done);
          r_q.push_back(in_ready);
        end
      end
    join
    first = -1; total = 0; run = 0; low = 0;
    for (int c = 0; c < v_q.size(); c++) begin
      if (v_q[c]) begin
        if (first < 0) first = c;
        total++;
      end
      if (!r_q[c]) low++;
    end
    if (first >= 0) begin
      for (int c = first; c < v_q.size() && v_q[c]; c++) run++;
    end
    check($sformatf("%s_run", tag), run, n*W);
    check($sformatf("%s_total", tag), total, n*W);
    check($sformatf("%s_ready_low", tag), low, exp_low);
    j = 0;
    for (int c = 0; c < v_q.size(); c++) begin
      if (v_q[c]) begin
        if (j < n*W) begin
          check($sformatf("%s_bit%0d", tag, j), b_q[c], tx_bit(words[j/W], j%W));
          check($sformatf("%s_done%0d", tag, j), d_q[c], ((j%W) == W-1));
        end
        j++;
      end
    end
    check($sformatf("%s_end_ready", tag), in_ready, 1);
    check($sformatf("%s_end_busy", tag), busy, 0);
  endtask

  // Reference model state for the random run.
  logic mq_bit[$];
  int   mq_idx[$];
  int   mq_edge[$];

  initial begin
    logic [W-1:0] words [4];
    logic         will_push;
    int           cur_edge;

    tbl[0] = '{word: 5'b01100, seq_lsb: 5'b00110, seq_msb: 5'b01100};
    tbl[1] = '{word: 5'b00110, seq_lsb: 5'b01100, seq_msb: 5'b00110};
    tbl[2] = '{word: 5'b11010, seq_lsb: 5'b01011, seq_msb: 5'b11010};
    tbl[3] = '{word: 5'b10010, seq_lsb: 5'b01001, seq_msb: 5'b10010};
    tbl[4] = '{word: 5'b01110, seq_lsb: 5'b01110, seq_msb: 5'b01110};
    tbl[5] = '{word: 5'b10001, seq_lsb: 5'b10001, seq_msb: 5'b10001};

    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    #12;
    check("rst_ser_bit", ser_bit, 0);
    check("rst_ser_valid", ser_valid, 0);
    check("rst_word_done", word_done, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b0;

    for (int t = 0; t < 6; t++) begin
`ifdef BIT_SERIALIZER_MSB_FIRST_EN
      run_single(tbl[t].word, tbl[t].seq_msb, $sformatf("single%0d", t));
`else
      run_single(tbl[t].word, tbl[t].seq_lsb, $sformatf("single%0d", t));
`endif
    end

    words[0] = 5'b11010; words[1] = 5'b10010; words[2] = 5'b01110; words[3] = 5'b00000;
    run_stream(words, 3, 4, "b2b");

    words[0] = 5'b10110; words[1] = 5'b00111; words[2] = 5'b11001; words[3] = 5'b01010;
    run_stream(words, 4, 8, "full");

    // Reset mid-word with a second word still queued.
    @(negedge clk);
    push_word(5'b10101);
    push_word(5'b11111);
    repeat (2) @(negedge clk);
    check("rstmid_pre_valid", ser_valid, 1);
    #2 rst = 1'b1;
    #1;
    check("rstmid_ser_bit", ser_bit, 0);
    check("rstmid_ser_valid", ser_valid, 0);
    check("rstmid_word_done", word_done, 0);
    check("rstmid_busy", busy, 0);
    check("rstmid_in_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("rstmid_no_residue_valid", ser_valid, 0);
      check("rstmid_no_residue_busy", busy, 0);
    end
`ifdef BIT_SERIALIZER_MSB_FIRST_EN
    run_single(tbl[0].word, tbl[0].seq_msb, "post_rst");
`else
    run_single(tbl[0].word, tbl[0].seq_lsb, "post_rst");
`endif

    // Randomized run: every accepted word appends its bits to the model queue,
    // stamped with the edge that accepted it.
    cur_edge = 0;
    @(posedge clk);
    #1;
    for (int cyc = 0; cyc < 440; cyc++) begin
      @(negedge clk);
      check("rnd_busy", busy, (mq_bit.size() != 0));
      if (mq_bit.size() == 0) begin
        check("rnd_idle_valid", ser_valid, 0);
      end else if (ser_valid) begin
        check("rnd_bit", ser_bit, mq_bit[0]);
        check("rnd_done", word_done, (mq_idx[0] == W-1));
        void'(mq_bit.pop_front());
        void'(mq_idx.pop_front());
        void'(mq_edge.pop_front());
      end else if (mq_edge[0] < cur_edge) begin
        // Data accepted before the latest edge must already be streaming.
        check("rnd_gap", ser_valid, 1);
      end
      will_push = in_valid && in_ready;
      @(posedge clk);
      cur_edge++;
      if (will_push) begin
        for (int i = 0; i < W; i++) begin
          mq_bit.push_back(tx_bit(in_data, i));
          mq_idx.push_back(i);
          mq_edge.push_back(cur_edge);
        end
      end
      #1;
      if (cyc >= 400) begin
        in_valid = 1'b0;
      end else if (will_push || !in_valid) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_data  = W'($urandom);
      end
    end
    check("rnd_drain", mq_bit.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_bit_serializer

// File: doc/bit_serializer.md
# bit_serializer

Parallel-to-serial front end for the `00110` Mealy sequence detector. It accepts WIDTH-bit words over a valid/ready handshake and buffers them in a small FIFO. It shifts each word out one bit per clock on `ser_bit`, which drives the detector's serial input `ip` directly. Back-to-back words stream with no idle bit between them, so patterns that straddle a word boundary stay detectable.

## Interface
- `WIDTH`, default 5: bits per input word, legal range 2..32.
- `DEPTH`, default 2: number of input FIFO entries, a power of two, at least 2.

- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_valid` input 1: `in_data` holds a word.
- `in_data` input WIDTH: word to serialize.
- `in_ready` output 1: FIFO can accept a word this cycle.
- `ser_bit` output 1: serial data bit; connects to the detector's `ip`.
- `ser_valid` output 1: `ser_bit` carries a payload bit this cycle.
- `word_done` output 1: one-cycle pulse while the last bit of a word is presented.
- `busy` output 1: FSM is in SHIFT or the FIFO is non-empty.

## Operation
- A push happens when `in_valid && in_ready` at a rising edge. A push with `in_ready` low is ignored; the source must hold `in_data` until accepted.
- `in_ready` is `count < DEPTH`, registered-count based. When the FIFO is full, `in_ready` stays 0 even if a pop occurs in the same cycle (no bypass). A push and a pop in the same cycle leave `count` unchanged.
- The FSM has two states, IDLE and SHIFT.
  - In IDLE with the FIFO non-empty: pop into the shift register, clear the bit counter, go to SHIFT.
  - In SHIFT: present the current bit, increment the bit counter, shift the register.
  - When `bitcnt == WIDTH-1`: assert `word_done`. If the FIFO is non-empty, pop the next word at that edge and stay in SHIFT (zero gap). Otherwise return to IDLE.
- Bit order is LSB first by default (`in_data[0]` first). See Configuration.
- In IDLE, `ser_bit` is 0 and `ser_valid` is 0.
- The bit counter width is `$clog2(WIDTH)`. FIFO pointers are `$clog2(DEPTH)` bits and wrap naturally; `count` is `$clog2(DEPTH)+1` bits.
- Reset at any time, including mid-word, abandons the word in flight and empties the FIFO. No partial word is resumed.

## Timing
- Reset values: `ser_bit`=0, `ser_valid`=0, `word_done`=0, `busy`=0, `in_ready`=1. FSM=IDLE, `count`=0, pointers=0.
- All outputs are registered.
- Latency: for a word pushed at edge N into an empty FIFO with the FSM in IDLE, bit 0 appears on `ser_bit`/`ser_valid` after edge N+1. The last bit appears after edge N+WIDTH.
- Word throughput is one word per WIDTH cycles when the FIFO stays non-empty.
- `word_done` coincides with the last bit's `ser_valid` cycle.
- The detector samples `ser_bit` at the next rising edge; no combinational path exists from the inputs to `ser_bit`.

## Configuration
- `BIT_SERIALIZER_MSB_FIRST_EN`:
  - Defined: transmit `in_data[WIDTH-1]` first; the shift register shifts left.
  - Undefined: LSB first, shift right.
- Latency, handshake and `word_done` timing are identical in both builds.

## Structure
- The shared package `serial_pkg` holds:
  - the state enum `ser_state_t` {IDLE, SHIFT};
  - the constant `SER_DEFAULT_WIDTH` = 5, also used by the detector bench;
  - the constant `SER_DEFAULT_DEPTH` = 2.
- One sub-module, `ser_fifo`: a synchronous FIFO parameterized by WIDTH/DEPTH, exposing `push`, `pop`, `full`, `empty`, `rdata` and `count`. The serializer FSM and shift register live in the top module.

## Test plan
- Reset mid-operation: assert `rst` at an arbitrary point. All outputs return to their reset values asynchronously. A word pushed after release streams from bit 0 with no residue.
- Single word (LSB-first build): push 5'b01100 at edge N.
  - `ser_bit` = 0,0,1,1,0 after edges N+1..N+5, with `ser_valid` high for exactly 5 cycles.
  - `word_done` is high only in the fifth cycle.
  - The downstream detector asserts `op` on the final 0.
- Back-to-back: push 5'b11010, 5'b10010, 5'b01110 with `in_valid` held high.
  - 15 consecutive `ser_valid` cycles with no gap.
  - `in_ready` drops to 0 while 2 words are queued and reasserts after the first pop.
- Full FIFO: with DEPTH=2, push 3 words while the FSM is shifting. The third word is held until `in_ready` returns to 1, and the held word is neither lost nor duplicated.
- MSB-first build: push 5'b00110. The `ser_bit` sequence is 0,0,1,1,0, with the same cycle timing as the single-word LSB-first case.
